vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, phase encoding and RGB332 field layout.
package vga_pkg;

  localparam int unsigned DefClkDiv = 4;

  localparam int unsigned DefHVis  = 640;
  localparam int unsigned DefHFp   = 16;
  localparam int unsigned DefHSync = 96;
  localparam int unsigned DefHBp   = 48;

  localparam int unsigned DefVVis  = 480;
  localparam int unsigned DefVFp   = 10;
  localparam int unsigned DefVSync = 2;
  localparam int unsigned DefVBp   = 33;

  localparam int unsigned CntW   = 10;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  // RGB332 bit positions within px_color
  localparam int unsigned RMsb = 7;
  localparam int unsigned RLsb = 5;
  localparam int unsigned GMsb = 4;
  localparam int unsigned GLsb = 2;
  localparam int unsigned BMsb = 1;
  localparam int unsigned BLsb = 0;

  typedef enum logic [1:0] {
    PhActive,
    PhFront,
    PhSync,
    PhBack
  } phase_e;

  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter plus its active/front/sync/back phase.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VIS  = DefHVis,
  parameter int unsigned FP   = DefHFp,
  parameter int unsigned SYNC = DefHSync,
  parameter int unsigned BP   = DefHBp
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [CntW-1:0] count,
  output phase_e          phase,
  output logic            wrap
);

  localparam int unsigned Total = axis_total(VIS, FP, SYNC, BP);

  localparam logic [CntW-1:0] LastAt  = CntW'(Total - 1);
  localparam logic [CntW-1:0] FrontAt = CntW'(VIS);
  localparam logic [CntW-1:0] SyncAt  = CntW'(VIS + FP);
  localparam logic [CntW-1:0] BackAt  = CntW'(VIS + FP + SYNC);

  logic [CntW-1:0] count_q, count_d;
  phase_e          phase_q, phase_d;

  assign wrap  = en && (count_q == LastAt);
  assign count = count_q;
  assign phase = phase_q;

  // Phase is decided from the next count so it always describes the current position.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + CntW'(1);
      unique case (phase_q)
        PhActive: if (count_d == FrontAt) phase_d = PhFront;
        PhFront:  if (count_d == SyncAt)  phase_d = PhSync;
        PhSync:   if (count_d == BackAt)  phase_d = PhBack;
        PhBack:   if (count_d == '0)      phase_d = PhActive;
        default:  phase_d = PhActive;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= PhActive;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, h/v axis counters, registered sync and colour.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv,
  parameter int unsigned H_VIS   = DefHVis,
  parameter int unsigned H_FP    = DefHFp,
  parameter int unsigned H_SYNC  = DefHSync,
  parameter int unsigned H_BP    = DefHBp,
  parameter int unsigned V_VIS   = DefVVis,
  parameter int unsigned V_FP    = DefVFp,
  parameter int unsigned V_SYNC  = DefVSync,
  parameter int unsigned V_BP    = DefVBp
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      px_color,
  output logic [CntW-1:0] hc,
  output logic [CntW-1:0] vc,
  output logic            pix_tick,
  output logic            frame_start,
  output logic            hsync,
  output logic            vsync,
  output logic [2:0]      vga_r,
  output logic [2:0]      vga_g,
  output logic [1:0]      vga_b
);

  localparam int unsigned       DivW    = $clog2(CLK_DIV);
  localparam logic [DivW-1:0]   DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            h_wrap, v_wrap, de;
  phase_e          h_phase, v_phase;

  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic [2:0] r_q, r_d, g_q, g_d;
  logic [1:0] b_q, b_d;

  assign pix_tick = (div_q == DivLast);
  assign div_d    = pix_tick ? '0 : div_q + DivW'(1);

  vga_axis_counter #(
    .VIS  (H_VIS),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_tick),
    .count (hc),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .VIS  (V_VIS),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (vc),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // v_wrap already implies h_wrap and pix_tick.
  assign frame_start = v_wrap;
  assign de          = (h_phase == PhActive) && (v_phase == PhActive);

  // Blanking selects constant zero so an undriven px_color cannot leak to the DAC.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (pix_tick) begin
      hsync_d = (h_phase != PhSync);
      vsync_d = (v_phase != PhSync);
      if (de) begin
        r_d = px_color[RMsb:RLsb];
        g_d = px_color[GMsb:GLsb];
        b_d = px_color[BMsb:BLsb];
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      div_q   <= div_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign vga_r = r_q;
  assign vga_g = g_q;
  assign vga_b = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: shrunken raster so whole frames fit in a short run, plus a CLK_DIV=2 copy.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = 25;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2, VT = 11;
  localparam int DivA = 4;
  localparam int DivB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] px, px_b;

  logic [9:0] a_hc, a_vc, b_hc, b_vc;
  logic       a_tick, a_fs, a_hs, a_vs, b_tick, b_fs, b_hs, b_vs;
  logic [2:0] a_r, a_g, b_r, b_g;
  logic [1:0] a_b, b_b;

  vga_timing_gen #(
    .CLK_DIV (DivA),
    .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) u_dut_a (
    .clk (clk), .rst (rst), .px_color (px),
    .hc (a_hc), .vc (a_vc), .pix_tick (a_tick), .frame_start (a_fs),
    .hsync (a_hs), .vsync (a_vs), .vga_r (a_r), .vga_g (a_g), .vga_b (a_b)
  );

  vga_timing_gen #(
    .CLK_DIV (DivB),
    .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) u_dut_b (
    .clk (clk), .rst (rst), .px_color (px_b),
    .hc (b_hc), .vc (b_vc), .pix_tick (b_tick), .frame_start (b_fs),
    .hsync (b_hs), .vsync (b_vs), .vga_r (b_r), .vga_g (b_g), .vga_b (b_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of DUT A
  int         md, mh, mv;
  logic       e_hs, e_vs, e_tick, e_fs;
  logic [7:0] e_rgb;
  int         pmode;

  int cyc = 0;
  int bad_hc, bad_vc, bad_tick, bad_fs, bad_hs, bad_vs, bad_rgb, rgb_x;
  int last_a, last_b, bad_gap_a, bad_gap_b;
  int fs_a0, fs_a1, fs_b0, fs_b1;
  int hs_len, hs_runs, bad_hs_run, vs_len, vs_runs, bad_vs_run;

  function automatic logic [7:0] pattern(input int h, input int v);
    return 8'(h * 37 + v * 11 + 5);
  endfunction

  task automatic model_reset();
    md = 0; mh = 0; mv = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
  endtask

  task automatic model_step();
    if (md == DivA - 1) begin
      e_rgb = (mh < HV && mv < VV) ? px : 8'h00;
      e_hs  = !(mh >= HV + HF && mh < HV + HF + HS);
      e_vs  = !(mv >= VV + VF && mv < VV + VF + VS);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      md = 0;
    end else begin
      md++;
    end
  endtask

  task automatic clear_stats();
    bad_hc = 0; bad_vc = 0; bad_tick = 0; bad_fs = 0; bad_hs = 0; bad_vs = 0; bad_rgb = 0;
    rgb_x = 0; bad_gap_a = 0; bad_gap_b = 0;
    hs_runs = 0; bad_hs_run = 0; vs_runs = 0; bad_vs_run = 0;
  endtask

  task automatic run_cycles(input int n);
    logic in_rst;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      in_rst = rst;
      if (in_rst) model_reset(); else model_step();
      @(negedge clk);
      e_tick = (md == DivA - 1);
      e_fs   = e_tick && mh == HT - 1 && mv == VT - 1;
      if (a_hc !== 10'(mh)) bad_hc++;
      if (a_vc !== 10'(mv)) bad_vc++;
      if (a_tick !== e_tick) bad_tick++;
      if (a_fs !== e_fs) bad_fs++;
      if (a_hs !== e_hs) bad_hs++;
      if (a_vs !== e_vs) bad_vs++;
      if ({a_r, a_g, a_b} !== e_rgb) bad_rgb++;
      if ($isunknown({a_r, a_g, a_b})) rgb_x++;
      if (in_rst) begin
        last_a = -1; last_b = -1; hs_len = 0; vs_len = 0;
      end else begin
        if (a_tick) begin
          if (last_a >= 0 && cyc - last_a != DivA) bad_gap_a++;
          last_a = cyc;
        end
        if (b_tick) begin
          if (last_b >= 0 && cyc - last_b != DivB) bad_gap_b++;
          last_b = cyc;
        end
        if (a_fs) begin
          if (fs_a0 < 0) fs_a0 = cyc; else if (fs_a1 < 0) fs_a1 = cyc;
        end
        if (b_fs) begin
          if (fs_b0 < 0) fs_b0 = cyc; else if (fs_b1 < 0) fs_b1 = cyc;
        end
        if (!a_hs) hs_len++;
        else if (hs_len > 0) begin
          hs_runs++;
          if (hs_len != HS * DivA) bad_hs_run++;
          hs_len = 0;
        end
        if (!a_vs) vs_len++;
        else if (vs_len > 0) begin
          vs_runs++;
          if (vs_len != VS * HT * DivA) bad_vs_run++;
          vs_len = 0;
        end
      end
      if (pmode == 0) px = 8'hE0;
      else px = (mh < HV && mv < VV) ? pattern(mh, mv) : 8'hxx;
    end
  endtask

  task automatic check_model(input string ph);
    check_eq({ph, "_hc_track"}, bad_hc, 0);
    check_eq({ph, "_vc_track"}, bad_vc, 0);
    check_eq({ph, "_tick_track"}, bad_tick, 0);
    check_eq({ph, "_fs_track"}, bad_fs, 0);
    check_eq({ph, "_hsync_track"}, bad_hs, 0);
    check_eq({ph, "_vsync_track"}, bad_vs, 0);
    check_eq({ph, "_rgb_track"}, bad_rgb, 0);
    check_eq({ph, "_rgb_x"}, rgb_x, 0);
  endtask

  int rel, first_tick, found;

  initial begin
    rst = 1'b1; px = 8'hE0; px_b = 8'h5A; pmode = 0;
    last_a = -1; last_b = -1; hs_len = 0; vs_len = 0;
    fs_a0 = -1; fs_a1 = -1; fs_b0 = -1; fs_b1 = -1;
    clear_stats();
    model_reset();
    @(negedge clk);
    run_cycles(3);

    // Reset state
    check_eq("rst_hc", a_hc, 0);
    check_eq("rst_vc", a_vc, 0);
    check_eq("rst_hsync", a_hs, 1);
    check_eq("rst_vsync", a_vs, 1);
    check_eq("rst_rgb", {a_r, a_g, a_b}, 0);
    check_eq("rst_tick", a_tick, 0);
    check_eq("rst_fs", a_fs, 0);
    check_eq("rst_b_hc", b_hc, 0);

    // Release and first-tick latency
    rst = 1'b0;
    rel = cyc;
    first_tick = -1;
    for (int k = 1; k <= DivA - 1; k++) begin
      run_cycles(1);
      if (a_tick && first_tick < 0) first_tick = k;
    end
    check_eq("first_tick_clk", first_tick, DivA - 1);
    check_eq("hc_before_first_tick", a_hc, 0);
    run_cycles(1);
    check_eq("hc_after_first_tick", a_hc, 1);

    // Two frames of constant red
    run_cycles(2300);
    check_model("red");
    check_eq("a_first_fs", fs_a0 - rel, DivA * HT * VT - 1);
    check_eq("a_fs_period", fs_a1 - fs_a0, DivA * HT * VT);
    check_eq("b_first_fs", fs_b0 - rel, DivB * HT * VT - 1);
    check_eq("b_fs_period", fs_b1 - fs_b0, DivB * HT * VT);
    check_eq("a_tick_gap", bad_gap_a, 0);
    check_eq("b_tick_gap", bad_gap_b, 0);
    check_eq("hsync_run_len", bad_hs_run, 0);
    check_eq("hsync_runs_seen", hs_runs >= 20, 1);
    check_eq("vsync_run_len", bad_vs_run, 0);
    check_eq("vsync_runs_seen", vs_runs >= 2, 1);

    // Varying colour, X during blanking
    clear_stats();
    pmode = 1;
    run_cycles(1200);
    check_model("pat");

    // Mid-frame reset while both syncs are low
    clear_stats();
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      run_cycles(1);
      if (mh == HV + HF + 1 && mv == VV + VF + 1) found = 1;
    end
    check_eq("reach_sync_pos", found, 1);
    check_eq("pre_rst_hsync_low", a_hs, 0);
    rst = 1'b1;
    run_cycles(1);
    rst = 1'b0;
    check_eq("mid_rst_hc", a_hc, 0);
    check_eq("mid_rst_vc", a_vc, 0);
    check_eq("mid_rst_hsync", a_hs, 1);
    check_eq("mid_rst_vsync", a_vs, 1);
    check_eq("mid_rst_rgb", {a_r, a_g, a_b}, 0);
    run_cycles(DivA - 1);
    check_eq("mid_rst_first_tick", a_tick, 1);
    run_cycles(1);
    check_eq("mid_rst_hc_one", a_hc, 1);
    run_cycles(1200);
    check_model("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
